cordic_polar_to_rect: RTL and testbench

Iterative CORDIC rotator that converts a polar pair (magnitude r, angle theta) into signed cartesian (x, y). It is the inverse of the team's existing |(x,y)| magnitude/square-root datapath: that block goes rectangular to magnitude, this one goes polar to rectangular. It is a sub-block behind the TinyTapeout top-level and is driven by a start/done handshake. One rotation stage is evaluated per clock to keep area small.

---
 rtl/cordic_polar_to_rect.sv | 174 +++++++++++++++++
 tb/tb_cordic_polar_to_rect.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_polar_to_rect.sv
// Iterative CORDIC rotator: polar (r, theta) in, signed cartesian (x, y) out.
// One micro-rotation per clock, start/done handshake.
// Optional build macro: CORDIC_ROUND_EN selects round-half-up on the final
// scale-down; without it the final scale-down truncates toward -infinity.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; x_out/y_out hold the last result
// ROTATE | one CORDIC stage per clock on x/y/z, iter counts stages
// FINISH | scale, quadrant-map and register result; done pulses next
module cordic_polar_to_rect #(
    parameter int ITER  = 8,
    parameter int OUT_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              r,
    input  logic [7:0]              theta,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] x_out,
    output logic signed [OUT_W-1:0] y_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [2:0] LAST_ITER = 3'(ITER - 1);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         quad;
    logic [2:0]         iter;
    logic signed [11:0] x_reg;
    logic signed [11:0] y_reg;
    logic signed [15:0] z_reg;

    logic [16:0]        r_prod;
    logic signed [11:0] x_init;
    logic signed [15:0] z_init;
    logic signed [11:0] x_sh;
    logic signed [11:0] y_sh;
    logic signed [11:0] x_rot;
    logic signed [11:0] y_rot;
    logic signed [15:0] z_rot;
    logic signed [12:0] x_ext;
    logic signed [12:0] y_ext;
    logic signed [10:0] xs;
    logic signed [10:0] ys;
    logic signed [10:0] x_map;
    logic signed [10:0] y_map;

    // atan(2^-i) with 16384 = 90 degrees
    function automatic logic signed [15:0] atan_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    atan_lut = 16'sd8192;
            3'd1:    atan_lut = 16'sd4836;
            3'd2:    atan_lut = 16'sd2555;
            3'd3:    atan_lut = 16'sd1297;
            3'd4:    atan_lut = 16'sd651;
            3'd5:    atan_lut = 16'sd326;
            3'd6:    atan_lut = 16'sd163;
            default: atan_lut = 16'sd81;
        endcase
    endfunction

    // Pre-scale r by 1/K (311/128) so the rotation gain lands back on r,
    // keeping 2 fractional bits; phase within the quadrant goes into z.
    assign r_prod = 17'(r) * 17'd311;
    assign x_init = 12'(r_prod >> 7);
    assign z_init = {2'b00, theta[5:0], 8'h00};

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ROTATE;
            ROTATE:  if (iter == LAST_ITER) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One CORDIC micro-rotation, direction chosen by the sign of z
    always_comb begin
        x_sh = x_reg >>> iter;
        y_sh = y_reg >>> iter;
        if (!z_reg[15]) begin
            x_rot = x_reg - y_sh;
            y_rot = y_reg + x_sh;
            z_rot = z_reg - atan_lut(iter);
        end else begin
            x_rot = x_reg + y_sh;
            y_rot = y_reg - x_sh;
            z_rot = z_reg + atan_lut(iter);
        end
    end

    // Drop the 2 fractional bits, then rotate into the requested quadrant
    always_comb begin
`ifdef CORDIC_ROUND_EN
        x_ext = {x_reg[11], x_reg} + 13'sd2;
        y_ext = {y_reg[11], y_reg} + 13'sd2;
`else
        x_ext = {x_reg[11], x_reg};
        y_ext = {y_reg[11], y_reg};
`endif
        xs = 11'(x_ext >>> 2);
        ys = 11'(y_ext >>> 2);
        x_map = xs;
        y_map = ys;
        case (quad)
            2'd1: begin x_map = -ys; y_map = xs;  end
            2'd2: begin x_map = -xs; y_map = -ys; end
            2'd3: begin x_map = ys;  y_map = -xs; end
            default: ;
        endcase
    end

    // Datapath registers and result/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quad  <= '0;
            iter  <= '0;
            x_reg <= '0;
            y_reg <= '0;
            z_reg <= '0;
            done  <= 1'b0;
            x_out <= '0;
            y_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quad  <= theta[7:6];
                        x_reg <= x_init;
                        y_reg <= '0;
                        z_reg <= z_init;
                        iter  <= '0;
                    end
                end
                ROTATE: begin
                    x_reg <= x_rot;
                    y_reg <= y_rot;
                    z_reg <= z_rot;
                    iter  <= iter + 3'd1;
                end
                FINISH: begin
                    x_out <= OUT_W'(x_map);
                    y_out <= OUT_W'(y_map);
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_polar_to_rect.sv
// Scoreboard bench for cordic_polar_to_rect: stimulus pushes expected
// (x, y, tolerance) per request, a negedge monitor pops on every done.
module tb_cordic_polar_to_rect;

    localparam int ITER  = 8;
    localparam int OUT_W = 10;

    typedef struct {
        int ex;
        int ey;
        int tol;
        int tag;
    } exp_t;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    start = 1'b0;
    logic [7:0]              r     = '0;
    logic [7:0]              theta = '0;
    logic                    busy;
    logic                    done;
    logic signed [OUT_W-1:0] x_out;
    logic signed [OUT_W-1:0] y_out;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    cordic_polar_to_rect #(.ITER(ITER), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .r     (r),
        .theta (theta),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string nm, input int act, input int exp_v, input int tol);
        checks++;
        if (act < exp_v - tol || act > exp_v + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp_v, tol);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with x=%0d y=%0d, expected no result",
                         x_out, y_out);
            end else begin
                e = sb_q.pop_front();
                check_val($sformatf("x_out[%0d]", e.tag), int'(x_out), e.ex, e.tol);
                check_val($sformatf("y_out[%0d]", e.tag), int'(y_out), e.ey, e.tol);
            end
        end
    end

    task automatic issue(input int rv, input int tv, input int ex, input int ey,
                         input int tol, input int tag);
        exp_t e;
        @(negedge clk);
        r     = 8'(rv);
        theta = 8'(tv);
        start = 1'b1;
        e.ex = ex; e.ey = ey; e.tol = tol; e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after acceptance until done is seen; busy must stay high meanwhile
    task automatic wait_done(input string nm, output int edges, output bit busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) return;
            if (!busy) busy_ok = 1'b0;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no done in %0d cycles, expected done", nm, edges);
    endtask

    task automatic convert(input int rv, input int tv, input int ex, input int ey,
                           input int tol, input int tag);
        int edges;
        bit busy_ok;
        issue(rv, tv, ex, ey, tol, tag);
        wait_done($sformatf("conv%0d", tag), edges, busy_ok);
        check_val($sformatf("latency[%0d]", tag), edges, ITER + 1, 0);
        check_val($sformatf("busy_inflight[%0d]", tag), int'(busy_ok), 1, 0);
        check_val($sformatf("busy_at_done[%0d]", tag), int'(busy), 0, 0);
        @(posedge clk);
        #1;
        check_val($sformatf("done_one_cycle[%0d]", tag), int'(done), 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int edges;
        int gap;
        bit busy_ok;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", int'(busy), 0, 0);
        check_val("rst_done", int'(done), 0, 0);
        check_val("rst_x",    int'(x_out), 0, 0);
        check_val("rst_y",    int'(y_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, expected = round(r*cos), round(r*sin)
        convert(200,   0,  200,    0, 2, 1);
        convert(200,  64,    0,  200, 2, 2);
        convert(200,  32,  141,  141, 2, 3);
        convert(255, 128, -255,    0, 2, 4);
        convert(255, 192,    0, -255, 2, 5);
        convert(100,  16,   92,   38, 2, 6);
        convert(128,  96,  -91,   91, 2, 7);
        convert(255, 224,  180, -180, 2, 8);

        // r = 0 gives exactly zero at every angle
        for (int t = 0; t < 256; t++) begin
            issue(0, t, 0, 0, 0, 1000 + t);
            wait_done("r0_sweep", edges, busy_ok);
        end

        // start held high: back-to-back requests, one every ITER+2 cycles,
        // r/theta changed while busy must not disturb the first result
        @(negedge clk);
        r = 8'd200; theta = 8'd0; start = 1'b1;
        sb_q.push_back('{ex: 200, ey: 0, tol: 2, tag: 20});
        sb_q.push_back('{ex: 92, ey: 38, tol: 2, tag: 21});
        @(posedge clk);
        #1 r = 8'd100; theta = 8'd16;
        wait_done("b2b_first", edges, busy_ok);
        check_val("b2b_first_latency", edges, ITER + 1, 0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b_second", gap, busy_ok);
        check_val("b2b_period", gap + 1, ITER + 2, 0);

        // Second start while busy is ignored
        issue(200, 64, 0, 200, 2, 30);
        repeat (3) @(posedge clk);
        #1 r = 8'd50; theta = 8'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignored_start", edges, busy_ok);
        check_val("ignored_start_latency", edges + 4, ITER + 1, 0);
        repeat (15) @(posedge clk);
        #1;

        // Reset mid-conversion aborts without a done pulse and clears outputs
        @(negedge clk);
        r = 8'd255; theta = 8'd128; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_busy", int'(busy), 0, 0);
        check_val("abort_done", int'(done), 0, 0);
        check_val("abort_x",    int'(x_out), 0, 0);
        check_val("abort_y",    int'(y_out), 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_val("abort_no_done", int'(done), 0, 0);
        convert(100, 16, 92, 38, 2, 40);

        repeat (15) @(posedge clk);
        #1;
        check_val("scoreboard_drained", sb_q.size(), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
